maxpool_conv_1: RTL
===================

# maxpool_conv_1

2x2/stride-2 max-pooling engine between the conv-1 result memory (26x26, 8-bit, one-cycle registered 2x2 window read) and the pooled-feature memory feeding the next layer. On `start` it walks all 13x13 pooling windows and issues one window read per cycle. It reduces each window's four signed values to their maximum and streams one pooled write per cycle. It then pulses `done`.

## Interface
- `n_c`, 26, conv-1 result columns
- `n_r`, 26, conv-1 result rows
- `dataWidthRstlConv`, 8, element width (signed two's complement)
- `addressWidthRstlConv`, 10, width of `radd1`/`radd2`
- `addressWidthPool`, 8, width of `wadd_pool` (must hold (n_r/2)*(n_c/2)-1)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  run request, sampled only in IDLE
- `ren`  out  1  read enable to the conv-1 result memory
- `radd1`  out  addressWidthRstlConv  window top-left row (full-resolution)
- `radd2`  out  addressWidthRstlConv  window top-left column (full-resolution)
- `rdata0..rdata3`  in  dataWidthRstlConv each  window (r,c),(r,c+1),(r+1,c),(r+1,c+1); valid the cycle after `ren`
- `wen_pool`  out  1  pooled-memory write strobe
- `wadd_pool`  out  addressWidthPool  pooled address, row-major
- `data_pool`  out  dataWidthRstlConv  pooled (max) value
- `busy`  out  1  high from first read cycle through last write cycle
- `done`  out  1  one-cycle pulse after last write

## Operation
- Pooled grid: PR = n_r/2 rows, PC = n_c/2 columns (floor). An odd last row or column is ignored. Default grid is 13x13, 169 windows.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: `start`=1 -> RUN; otherwise stay.
  - RUN: per cycle `ren`=1, `radd1`=2*pr, `radd2`=2*pc. Counters advance pc-fastest. After window (PR-1,PC-1) -> DRAIN.
  - DRAIN: 2 cycles, no reads; pipeline empties -> DONE.
  - DONE: `done`=1 for 1 cycle -> IDLE.
- `start` outside IDLE is ignored. A `start` held high in IDLE across DONE->IDLE launches a new run the following cycle.
- Pipeline:
  - Stage A: read issue.
  - Stage B: the cycle rdata is valid. Signed max of the four values is registered, along with a valid bit and a write address delayed to match.
  - Stage C: `wen_pool`/`data_pool`/`wadd_pool` are driven from the stage-B registers.
- Max is a signed compare, e.g. max(-128,-1,-5,-2) = -1. Outputs are bit-exact copies of one input; no saturation or widening.
- `wadd_pool` = pr*PC+pc of the window. It runs 0,1,...,PR*PC-1 contiguously with no gaps or repeats.
- `radd1`/`radd2` hold their last value when `ren`=0. `wadd_pool`/`data_pool` hold their last value when `wen_pool`=0.

## Timing
- Reset: every output is 0, the state is IDLE, and counters and pipeline valid bits are cleared.
- Reset asserted mid-run aborts immediately. No further `ren`/`wen_pool` appears and no `done` pulse is issued. The next run starts from window 0.
- Cycle 0: `start` is sampled high in IDLE. Cycles 1..PR*PC: `ren`=1 (1..169 by default).
- Read issued in cycle k is written in cycle k+2. `wen_pool`=1 in cycles 3..PR*PC+2 (3..171).
- `busy`=1 in cycles 1..PR*PC+2.
- `done`=1 in cycle PR*PC+3 (172), with `busy`=0.
- Throughput is 1 window per cycle, with no bubbles between windows. There is no backpressure: the consumer memory must accept every write.

## Test plan
- Ramp: conv memory holds value (r*26+c) mod 128. Required response: 169 writes, where write i for window (pr,pc) = ((2pr+1)*26+2pc+1) mod 128 (the bottom-right element, except at mod-wrap boundaries, which are checked explicitly). `done` at cycle 172.
- Position sweep: in each window the max sits in rdata0, then rdata1, rdata2, rdata3 (rotating per window), with the others set to -7. Required response: `data_pool` equals the placed max (e.g. 42) every time.
- Negatives: window {-128,-1,-5,-2} -> `data_pool`=-1 (0xFF). Window {0,-128,-128,-128} -> 0.
- Reset at cycle 50: assert `rst_n`=0 for 2 cycles. Required response: outputs go 0 at once, with no `done`. A new `start` then produces `wadd_pool` starting at 0 and 169 writes in total.
- `start` pulsed at cycles 10 and 100 during a run: ignored; exactly 169 writes and one `done`.
- Back-to-back runs: `start` held high continuously. Required response: the second run's first `ren` appears 2 cycles after `done` (DONE -> IDLE -> RUN), and address sequences are identical in both runs.

Source files
------------

// File: rtl/maxpool_conv_1.sv
// maxpool_conv_1: 2x2/stride-2 signed max-pooling engine.
// Walks the conv-1 result grid window by window, streams one pooled write per cycle.
module maxpool_conv_1 #(
    parameter int n_c                  = 26,
    parameter int n_r                  = 26,
    parameter int dataWidthRstlConv    = 8,
    parameter int addressWidthRstlConv = 10,
    parameter int addressWidthPool     = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            ren,
    output logic [addressWidthRstlConv-1:0] radd1,
    output logic [addressWidthRstlConv-1:0] radd2,
    input  logic [dataWidthRstlConv-1:0]    rdata0,
    input  logic [dataWidthRstlConv-1:0]    rdata1,
    input  logic [dataWidthRstlConv-1:0]    rdata2,
    input  logic [dataWidthRstlConv-1:0]    rdata3,
    output logic                            wen_pool,
    output logic [addressWidthPool-1:0]     wadd_pool,
    output logic [dataWidthRstlConv-1:0]    data_pool,
    output logic                            busy,
    output logic                            done
);

    localparam int AW = addressWidthRstlConv;
    localparam int DW = dataWidthRstlConv;
    localparam int PW = addressWidthPool;
    localparam int PR = n_r / 2;
    localparam int PC = n_c / 2;

    localparam logic [AW-1:0] PR_LAST = AW'(PR - 1);
    localparam logic [AW-1:0] PC_LAST = AW'(PC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Pooled-grid window counters; they hold after the last window so
    // the read address stays stable until the next run clears them.
    logic [AW-1:0] pr;
    logic [AW-1:0] pc;
    logic [PW-1:0] wcnt;
    logic          drain_cnt;
    logic          last_win;

    // Stage B registers: rdata valid flag and matching write address.
    logic          vld_a;
    logic [PW-1:0] wadd_a;

    // Stage C registers: registered max, its address and valid bit.
    logic          vld_b;
    logic [PW-1:0] wadd_b;
    logic [DW-1:0] max_b;

    // Signed view of the window for the max tree.
    logic signed [DW-1:0] s0;
    logic signed [DW-1:0] s1;
    logic signed [DW-1:0] s2;
    logic signed [DW-1:0] s3;
    logic signed [DW-1:0] m01;
    logic signed [DW-1:0] m23;
    logic signed [DW-1:0] win_max;

    assign last_win = (pr == PR_LAST) && (pc == PC_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-state control outputs.
    always_comb begin
        state_nxt = state;
        ren       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                ren  = 1'b1;
                busy = 1'b1;
                if (last_win) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Window walk: pc fastest, cleared on launch, frozen on the last window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr   <= '0;
            pc   <= '0;
            wcnt <= '0;
        end else if (state == IDLE && start) begin
            pr   <= '0;
            pc   <= '0;
            wcnt <= '0;
        end else if (state == RUN && !last_win) begin
            wcnt <= wcnt + 1'b1;
            if (pc == PC_LAST) begin
                pc <= '0;
                pr <= pr + 1'b1;
            end else begin
                pc <= pc + 1'b1;
            end
        end
    end

    // Two-cycle drain timer so the last write lands before done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= 1'b0;
        end else if (state == DRAIN) begin
            drain_cnt <= ~drain_cnt;
        end else begin
            drain_cnt <= 1'b0;
        end
    end

    // Full-resolution top-left corner of the current window.
    assign radd1 = {pr[AW-2:0], 1'b0};
    assign radd2 = {pc[AW-2:0], 1'b0};

    assign s0 = rdata0;
    assign s1 = rdata1;
    assign s2 = rdata2;
    assign s3 = rdata3;

    // Signed max of the four window elements as a two-level tree.
    always_comb begin
        m01     = (s0 >= s1) ? s0 : s1;
        m23     = (s2 >= s3) ? s2 : s3;
        win_max = (m01 >= m23) ? m01 : m23;
    end

    // Read-issue side: mark the cycle rdata is valid and carry its address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_a  <= 1'b0;
            wadd_a <= '0;
        end else begin
            vld_a <= ren;
            if (ren) begin
                wadd_a <= wcnt;
            end
        end
    end

    // Register the max; data and address hold while no write is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_b  <= 1'b0;
            wadd_b <= '0;
            max_b  <= '0;
        end else begin
            vld_b <= vld_a;
            if (vld_a) begin
                wadd_b <= wadd_a;
                max_b  <= win_max;
            end
        end
    end

    assign wen_pool  = vld_b;
    assign wadd_pool = wadd_b;
    assign data_pool = max_b;

endmodule
